// File: rtl/counter_load_seq.sv
// Preset sequencer for an 8-bit loadable up-counter: queues presets,
// then issues a load pulse followed by a run_len-cycle enable window.
module counter_load_seq #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int RUN_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     run,
   input  logic [RUN_W-1:0]         run_len,
   input  logic                     flush,
   output logic                     load,
   output logic [DATA_W-1:0]        data_out,
   output logic                     enable,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PAUSE
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [RUN_W-1:0]  rem_q, rem_d;
   logic              done_q, done_d;
   logic              full, empty, push, pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full && !flush;
   assign pop      = (state_q == S_IDLE) && !empty && run && !flush;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_LOAD;
               dout_d  = mem_q[rd_ptr_q];
            end
         end
         S_LOAD: begin
            rem_d   = run_len;
            state_d = (run_len != '0) ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            // Decrement every enable-high cycle so pauses never stretch the window
            rem_d = rem_q - RUN_W'(1);
            if (rem_q == RUN_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (!run) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (run) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         rem_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= in_data;
   end

   assign load     = (state_q == S_LOAD);
   assign enable   = (state_q == S_RUN);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign data_out = dout_q;
   assign level    = level_q;

endmodule
